// File: rtl/uart_pkg.sv
// Shared defaults and FSM encoding for the UART transmit path.
// Latency/backpressure: none (declarations only).
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the serializer; a write is visible at head one cycle later.
// Backpressure: pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_dat,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [7:0]    head,
  output logic [CW-1:0] count
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter behind a byte FIFO; start bit leaves one cycle after the accept edge.
// Backpressure: io_dataIn_ready drops while the FIFO is full and while in reset.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] io_dataIn_bits,
  input  logic       io_dataIn_valid,
  output logic       io_dataIn_ready,
  output logic       io_pair_tx,
  output logic       io_txDone,
  output logic       io_busy
);
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shreg, shreg_n;
  logic           tx_q, tx_n;
  logic           done_q, done_n;
  logic           rst_q;
  logic           pop;
  logic           push;
  logic           bit_end;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_head;
  logic [FCW-1:0] fifo_count;

  assign push            = io_dataIn_valid && io_dataIn_ready;
  assign io_dataIn_ready = !fifo_full && !rst_q;
  assign io_pair_tx      = tx_q;
  assign io_txDone       = done_q;
  assign io_busy         = (state != IDLE) || (fifo_count != '0);
  assign bit_end         = (cnt == CNT_LAST);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (io_dataIn_bits),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx_q;
    done_n    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_head;
          tx_n    = 1'b0;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          tx_n      = shreg[0];
          state_n   = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            // The line shows shreg[0]; after the shift the next bit sits at [1] of the old value.
            bit_idx_n = bit_idx + 1'b1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n  = '0;
          done_n = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_n = fifo_head;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
      rst_q   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: single-frame vector table plus back-to-back, wrap, reset and push/pop sequences.
module tb_uart_tx;
  localparam int OS    = 16;
  localparam int FRAME = 10 * OS;

  logic       clock;
  logic       reset;
  logic [7:0] io_dataIn_bits;
  logic       io_dataIn_valid;
  logic       io_dataIn_ready;
  logic       io_pair_tx;
  logic       io_txDone;
  logic       io_busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // frame[i] is the i-th bit on the line: start, d0..d7, stop
  } vec_t;
  vec_t vecs[6];

  logic [7:0] offer_q[$];
  logic [7:0] exp_q[$];
  int         acc_cyc[$];
  int         acc_at10;
  logic       rdy_at10;

  uart_tx #(.OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .io_dataIn_bits  (io_dataIn_bits),
    .io_dataIn_valid (io_dataIn_valid),
    .io_dataIn_ready (io_dataIn_ready),
    .io_pair_tx      (io_pair_tx),
    .io_txDone       (io_txDone),
    .io_busy         (io_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic push_byte(input logic [7:0] d);
    io_dataIn_bits  = d;
    io_dataIn_valid = 1'b1;
    tick();
    io_dataIn_valid = 1'b0;
    io_dataIn_bits  = ~d;
  endtask

  function automatic logic line_bit(input int j);
    int f, b;
    logic [7:0] d;
    f = j / FRAME;
    b = (j / OS) % 10;
    d = exp_q[f];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  task automatic frame_vec(input string name, input logic [7:0] d, input logic [9:0] fr);
    int bad;
    push_byte(d);
    chk({name, "_pre"}, io_pair_tx, 1);
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < OS; c++) begin
        tick();
        if (io_pair_tx !== fr[b] || io_txDone !== 1'b0) bad++;
      end
      chk($sformatf("%s_bit%0d", name, b), bad, 0);
    end
    tick();
    chk({name, "_done"}, io_txDone, 1);
    chk({name, "_idle_tx"}, io_pair_tx, 1);
    tick();
    chk({name, "_done_once"}, io_txDone, 0);
    chk({name, "_busy_end"}, io_busy, 0);
  endtask

  // Offers offer_q with valid held, honouring ready, and checks the line for n gapless frames.
  task automatic run_stream(input string name);
    int   n, total, dones, bad, gap, j;
    logic will;
    n     = offer_q.size();
    total = n * FRAME + 2;
    dones = 0; bad = 0; gap = 0;
    exp_q = offer_q;
    acc_cyc.delete();
    io_dataIn_valid = 1'b1;
    io_dataIn_bits  = offer_q[0];
    for (int c = 0; c < total; c++) begin
      will = io_dataIn_valid && io_dataIn_ready;
      tick();
      if (will) begin
        acc_cyc.push_back(c);
        void'(offer_q.pop_front());
      end
      if (offer_q.size() == 0) io_dataIn_valid = 1'b0;
      else io_dataIn_bits = offer_q[0];
      if (c >= 1) begin
        j = c - 1;
        if (j < n * FRAME) begin
          if (io_pair_tx !== line_bit(j)) bad++;
          if (io_busy !== 1'b1) gap++;
        end
        if (io_txDone === 1'b1) dones++;
      end
      if (c == 10) begin
        acc_at10 = acc_cyc.size();
        rdy_at10 = io_dataIn_ready;
      end
    end
    chk({name, "_line"}, bad, 0);
    chk({name, "_no_gap"}, gap, 0);
    chk({name, "_dones"}, dones, n);
    chk({name, "_busy_end"}, io_busy, 0);
    chk({name, "_accepted"}, acc_cyc.size(), n);
  endtask

  initial begin
    int bad;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};
    vecs[5] = '{8'h5A, 10'b1010110100};

    reset           = 1'b1;
    io_dataIn_valid = 1'b0;
    io_dataIn_bits  = 8'h00;
    repeat (3) tick();
    chk("rst_tx", io_pair_tx, 1);
    chk("rst_busy", io_busy, 0);
    chk("rst_ready", io_dataIn_ready, 0);
    chk("rst_done", io_txDone, 0);
    chk("rst_count", dut.u_fifo.count, 0);
    reset = 1'b0;
    chk("rst_ready_hold", io_dataIn_ready, 0);
    tick();
    chk("ready_after_rst", io_dataIn_ready, 1);

    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (io_pair_tx !== 1'b1 || io_busy !== 1'b0 || io_dataIn_ready !== 1'b1 || io_txDone !== 1'b0) bad++;
    end
    chk("idle_500", bad, 0);

    for (int i = 0; i < 6; i++)
      frame_vec($sformatf("vec%0d_%02h", i, vecs[i].data), vecs[i].data, vecs[i].frame);

    // Six bytes with valid held: five accepted on consecutive edges, sixth when frame one ends.
    offer_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_stream("b2b");
    chk("b2b_acc_at10", acc_at10, 5);
    chk("b2b_ready_full", rdy_at10, 0);
    chk("b2b_fifth_cyc", acc_cyc[4], 4);
    chk("b2b_sixth_cyc", acc_cyc[5], 162);

    offer_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    run_stream("wrap");

    // Reset at cycle 80 of a 0x3C frame with two bytes queued.
    repeat (3) tick();
    push_byte(8'h3C);
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (78) tick();
    chk("midrst_pre_count", dut.u_fifo.count, 2);
    chk("midrst_pre_busy", io_busy, 1);
    reset = 1'b1;
    tick();
    chk("midrst_tx", io_pair_tx, 1);
    chk("midrst_busy", io_busy, 0);
    chk("midrst_done", io_txDone, 0);
    chk("midrst_count", dut.u_fifo.count, 0);
    chk("midrst_ready", io_dataIn_ready, 0);
    reset = 1'b0;
    tick();
    chk("midrst_ready_back", io_dataIn_ready, 1);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (io_pair_tx !== 1'b1 || io_txDone !== 1'b0 || io_busy !== 1'b0) bad++;
    end
    chk("midrst_quiet", bad, 0);

    // Push lands on the same edge that pops at count 2.
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    chk("pp_pre_count", dut.u_fifo.count, 2);
    repeat (158) tick();
    push_byte(8'hC4);
    chk("pp_count", dut.u_fifo.count, 2);
    chk("pp_done", io_txDone, 1);
    exp_q = '{8'hC2, 8'hC3, 8'hC4};
    bad = 0;
    for (int j = 0; j < 3 * FRAME; j++) begin
      if (io_pair_tx !== line_bit(j)) bad++;
      tick();
    end
    chk("pp_order", bad, 0);
    chk("pp_last_done", io_txDone, 1);
    chk("pp_busy_end", io_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
